// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter and its slots.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Register 0 is hardwired to zero, so writes to it are discarded.
  localparam int REG_ZERO = 0;

  // Identifies which writeback source owns a grant or the round-robin turn.
  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback buffer: valid/ready intake, register-0 drop, age tag.
// The age bit is set when this slot loads while the other slot keeps an
// older entry, and cleared when the other slot loads behind this one.
module wb_slot
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  output logic              ready,
  input  logic [ADDR_W-1:0] dst,
  input  logic [DATA_W-1:0] data,
  input  logic              grant,
  input  logic              other_holds,
  input  logic              other_loads,
  output logic              full,
  output logic              load,
  output logic              age,
  output logic [ADDR_W-1:0] held_reg,
  output logic [DATA_W-1:0] held_data
);

  logic accept;

  // A draining slot can refill on the same edge; ready never looks at valid.
  assign ready  = !full || grant;
  assign accept = valid && ready;
  assign load   = accept && (dst != ADDR_W'(REG_ZERO));

  // Occupancy and age tracking; a register-0 accept completes but stays empty.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    if (rst) begin
      full <= 1'b0;
      age  <= 1'b0;
    end else if (accept) begin
      full <= load;
      if (load) age <= other_holds;
    end else if (grant) begin
      full <= 1'b0;
    end else if (other_loads && full) begin
      age <= 1'b0;
    end
  end

  // Payload capture on load.
  always_ff @(posedge clk) begin
    // NOTE: the payload is left unreset; it is only observed while full is
    // set, and full itself is reset.
    if (load) begin
      held_reg  <= dst;
      held_data <= data;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between a single-cycle source (A) and
// a multi-cycle source (B) through one-entry slots and a round-robin arbiter.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ADDR_W-1:0]    a_reg,
  input  logic [DATA_W-1:0]    a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [ADDR_W-1:0]    b_reg,
  input  logic [DATA_W-1:0]    b_data,
  output logic                 RegWrite,
  output logic [ADDR_W-1:0]    wr_reg,
  output logic [DATA_W-1:0]    wr_data,
  output logic [2**ADDR_W-1:0] pending
);

  logic              a_full, a_load, a_age;
  logic              b_full, b_load, b_age;
  logic [ADDR_W-1:0] a_held_reg, b_held_reg;
  logic [DATA_W-1:0] a_held_data, b_held_data;
  logic              grant_a, grant_b, contested;
  src_e              ptr, winner;

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
    .clk         (clk),
    .rst         (rst),
    .valid       (a_valid),
    .ready       (a_ready),
    .dst         (a_reg),
    .data        (a_data),
    .grant       (grant_a),
    .other_holds (b_full && !grant_b),
    .other_loads (b_load),
    .full        (a_full),
    .load        (a_load),
    .age         (a_age),
    .held_reg    (a_held_reg),
    .held_data   (a_held_data)
  );

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_b (
    .clk         (clk),
    .rst         (rst),
    .valid       (b_valid),
    .ready       (b_ready),
    .dst         (b_reg),
    .data        (b_data),
    .grant       (grant_b),
    .other_holds (a_full && !grant_a),
    .other_loads (a_load),
    .full        (b_full),
    .load        (b_load),
    .age         (b_age),
    .held_reg    (b_held_reg),
    .held_data   (b_held_data)
  );

  // Grant selection from slot state only; same-register pairs drain oldest first.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the block can infer a latch.
    contested = a_full && b_full;
    winner    = SRC_A;
    if (contested) begin
      if (a_held_reg == b_held_reg) winner = (a_age && !b_age) ? SRC_B : SRC_A;
      else                          winner = ptr;
    end else if (b_full) begin
      winner = SRC_B;
    end
    grant_a = a_full && (winner == SRC_A);
    grant_b = b_full && (winner == SRC_B);
  end

  // Round-robin pointer moves to the loser after every contested grant.
  always_ff @(posedge clk) begin
    if (rst)            ptr <= SRC_A;
    else if (contested) ptr <= (winner == SRC_A) ? SRC_B : SRC_A;
  end

  // Register file write port driven from the granted slot, zero when idle.
  always_comb begin
    RegWrite = 1'b0;
    wr_reg   = '0;
    wr_data  = '0;
    if (grant_a) begin
      RegWrite = 1'b1;
      wr_reg   = a_held_reg;
      wr_data  = a_held_data;
    end else if (grant_b) begin
      RegWrite = 1'b1;
      wr_reg   = b_held_reg;
      wr_data  = b_held_data;
    end
  end

  // Pending-write mask over buffered destinations, including one draining now.
  always_comb begin
    pending = '0;
    if (a_full) pending[a_held_reg] = 1'b1;
    if (b_full) pending[b_held_reg] = 1'b1;
    pending[REG_ZERO] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;
  logic        reg_write;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [31:0] pending;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_reg    (a_reg),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_reg    (b_reg),
    .b_data   (b_data),
    .RegWrite (reg_write),
    .wr_reg   (wr_reg),
    .wr_data  (wr_data),
    .pending  (pending)
  );

  // One cycle: inputs driven during the cycle, outputs expected in that cycle.
  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  br;
    logic [31:0] bd;
    logic        e_ardy;
    logic        e_brdy;
    logic        e_we;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic [31:0] e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic av, logic [4:0] ar, logic [31:0] ad,
                              logic bv, logic [4:0] br, logic [31:0] bd,
                              logic e_ardy, logic e_brdy, logic e_we,
                              logic [4:0] e_reg, logic [31:0] e_data,
                              logic [31:0] e_pend);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad;
    v.bv = bv; v.br = br; v.bd = bd;
    v.e_ardy = e_ardy; v.e_brdy = e_brdy; v.e_we = e_we;
    v.e_reg = e_reg; v.e_data = e_data; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " RegWrite"}, 64'(reg_write), 64'd0);
    check({tag, " wr_reg"},   64'(wr_reg),    64'd0);
    check({tag, " wr_data"},  64'(wr_data),   64'd0);
    check({tag, " pending"},  64'(pending),   64'd0);
    check({tag, " a_ready"},  64'(a_ready),   64'd1);
    check({tag, " b_ready"},  64'(b_ready),   64'd1);
  endtask

  initial begin
    // Reset state, then lone write r5.
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       1, 1, 0, 0,  0,        0));
    vecs.push_back(mk(1, 5, 'h1234,   0, 0, 0,       1, 1, 0, 0,  0,        0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       1, 1, 1, 5,  'h1234,   'h20));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       1, 1, 0, 0,  0,        0));
    // A r3 / B r4 together, then both again with the pointer now on B.
    vecs.push_back(mk(1, 3, 'hA,      1, 4, 'hB,     1, 1, 0, 0,  0,        0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       1, 0, 1, 3,  'hA,      'h18));
    vecs.push_back(mk(1, 13, 'hC,     1, 14, 'hD,    1, 1, 1, 4,  'hB,      'h10));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       0, 1, 1, 14, 'hD,      'h6000));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       1, 1, 1, 13, 'hC,      'h2000));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       1, 1, 0, 0,  0,        0));
    // Register 0 write is accepted and dropped.
    vecs.push_back(mk(1, 0, 'hFFFF,   0, 0, 0,       1, 1, 0, 0,  0,        0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       1, 1, 0, 0,  0,        0));
    // B r7=1 waits behind A r6, A then loads r7=2: older B drains first.
    vecs.push_back(mk(1, 6, 'h66,     1, 7, 1,       1, 1, 0, 0,  0,        0));
    vecs.push_back(mk(1, 7, 2,        0, 0, 0,       1, 0, 1, 6,  'h66,     'hC0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       0, 1, 1, 7,  1,        'h80));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       1, 1, 1, 7,  2,        'h80));
    // Same-register tie loaded on one edge with pointer on B: A wins anyway.
    vecs.push_back(mk(1, 1, 'h11,     1, 2, 'h22,    1, 1, 0, 0,  0,        0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       1, 0, 1, 1,  'h11,     'h6));
    vecs.push_back(mk(1, 9, 'h91,     1, 9, 'h92,    1, 1, 1, 2,  'h22,     'h4));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       1, 0, 1, 9,  'h91,     'h200));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       1, 1, 1, 9,  'h92,     'h200));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       1, 1, 0, 0,  0,        0));

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].bv, vecs[i].br, vecs[i].bd);
      #4;
      check($sformatf("v%0d a_ready", i),  64'(a_ready),   64'(vecs[i].e_ardy));
      check($sformatf("v%0d b_ready", i),  64'(b_ready),   64'(vecs[i].e_brdy));
      check($sformatf("v%0d RegWrite", i), 64'(reg_write), 64'(vecs[i].e_we));
      check($sformatf("v%0d wr_reg", i),   64'(wr_reg),    64'(vecs[i].e_reg));
      check($sformatf("v%0d wr_data", i),  64'(wr_data),   64'(vecs[i].e_data));
      check($sformatf("v%0d pending", i),  64'(pending),   64'(vecs[i].e_pend));
      next_cycle();
    end

    // A streams 8 writes back-to-back with B idle.
    for (int i = 0; i <= 8; i++) begin
      drive(i < 8, 5'(i + 1), 32'h100 + 32'(i), 0, 0, 0);
      #4;
      check($sformatf("stream%0d a_ready", i), 64'(a_ready), 64'd1);
      if (i == 0) begin
        check("stream0 RegWrite", 64'(reg_write), 64'd0);
      end else begin
        check($sformatf("stream%0d RegWrite", i), 64'(reg_write), 64'd1);
        check($sformatf("stream%0d wr_reg", i),   64'(wr_reg),    64'(i));
        check($sformatf("stream%0d wr_data", i),  64'(wr_data),   64'(32'h100 + 32'(i - 1)));
        check($sformatf("stream%0d pending", i),  64'(pending),   64'(32'd1 << i));
      end
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    #4;
    check_idle("stream_end");
    next_cycle();

    // Reset with both slots full and new handshakes offered during reset.
    drive(1, 10, 'hAA, 1, 11, 'hBB);
    #4;
    check("rst_load RegWrite", 64'(reg_write), 64'd0);
    next_cycle();
    rst = 1'b1;
    drive(1, 12, 'hCC, 1, 13, 'hDD);
    #4;
    check("rst_cycle pending", 64'(pending), 64'h0C00);
    next_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #4;
    check_idle("post_rst");
    next_cycle();
    #4;
    check_idle("post_rst2");
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between two writeback sources: A, the single-cycle ALU/load path, and B, the multi-cycle unit such as mul/div. Each source hands over a destination/data pair with a valid/ready handshake into a one-entry slot. A round-robin arbiter drains one slot per cycle onto the register file write port. A pending-write mask lets issue logic stall on in-flight destinations.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width; register 0 is hardwired zero

Ports:
- clk  in  1  rising-edge clock shared with the register file
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  source A offers a write
- a_ready  out  1  source A slot can accept this cycle
- a_reg  in  ADDR_W  source A destination register
- a_data  in  DATA_W  source A write data
- b_valid, b_ready, b_reg, b_data: same as the A signals, for source B
- RegWrite  out  1  write enable to the register file
- wr_reg  out  ADDR_W  write address to the register file
- wr_data  out  DATA_W  write data to the register file
- pending  out  2**ADDR_W  bit r set while a write to register r is buffered

## Operation
- Slots:
  - Each source owns one slot: full flag, reg, data, and a sequence tag (age bit).
  - Accept happens when x_valid && x_ready at the clock edge.
  - x_ready = !full_x || grant_x. The slot refills in the same cycle it drains.
  - x_ready does not depend on x_valid, so there is no combinational loop.
- Register 0 filter:
  - An accepted write with x_reg == 0 completes the handshake.
  - It is discarded. The slot stays empty and RegWrite is never asserted for it.
- Arbitration is evaluated each cycle from slot state only:
  - No slot full: no grant.
  - One slot full: that slot is granted.
  - Both full, different regs: the round-robin pointer picks. Pointer value 0 favours A, 1 favours B.
  - After a contested grant, the pointer moves to the loser.
  - An uncontested grant leaves the pointer unchanged.
  - Both full, same reg: the older slot is granted, regardless of the pointer. If both were loaded on the same edge, A is treated as older. The pointer still moves to the loser.
- Write port outputs:
  - RegWrite = any grant.
  - wr_reg and wr_data come from the granted slot, combinationally.
  - When RegWrite = 0, wr_reg = 0 and wr_data = 0.
  - The register file captures the write on the same edge that empties the slot.
- pending:
  - OR of one-hot(reg) over the full slots. Bit 0 is always 0.
  - Combinational from slot state; it includes a slot being granted this cycle.

## Timing
- Reset state (after any edge with rst = 1):
  - Both slots empty, pointer = 0, age bits cleared.
  - RegWrite = 0, wr_reg = 0, wr_data = 0, pending = 0.
  - a_ready = b_ready = 1.
- Reset mid-operation: buffered writes are dropped and never reach the register file. Handshakes offered during the reset cycle are not accepted.
- Latency:
  - A write accepted at edge N is visible on the write port during cycle N+1.
  - Uncontended, it lands in the register file at edge N+1.
  - Under contention the worst case is edge N+2.
- Throughput:
  - One register-file write per cycle.
  - A lone streaming source sustains one accept per cycle.
  - Two streaming sources each get one write every 2 cycles, alternating.
- Backpressure: a source whose slot is full and not granted sees x_ready = 0. It must hold valid, reg and data stable until accepted.

## Structure
- Shared package (regfile_pkg):
  - DATA_W and ADDR_W defaults.
  - REG_ZERO constant.
  - Source-select enum {SRC_A, SRC_B}.
- Sub-module wb_slot: one-entry buffer with ready logic, register 0 drop and age tag. Instantiated twice.
- Arbiter, pointer and pending-mask logic live in the top level.

## Test plan
- A alone writes r5 = 0x1234 at edge 1 -> RegWrite = 1, wr_reg = 5, wr_data = 0x1234 in cycle 2. pending[5] = 1 in cycle 2 only.
- A (r3 = 0xA) and B (r4 = 0xB) accepted on the same edge, then both again -> writes in order r3, r4, then B's write first, then A's. a_ready/b_ready deassert on the losing side.
- A offers r0 = 0xFFFF -> handshake completes, RegWrite stays 0, pending = 0.
- B loads r7 = 1, then A loads r7 = 2 one edge later while B waits behind a prior A write -> r7 written with 1 before 2. Final register value is 2 regardless of pointer.
- A streams 8 writes back-to-back with B idle -> a_ready stays 1, 8 consecutive RegWrite cycles.
- Both slots full, rst asserted for one cycle -> RegWrite = 0 in the following cycle, pending = 0, neither buffered write appears, ready = 1.
